bird_game_ctrl: RTL

Top-level sequencer for the Flappy Bird bird column and pipe logic. Divides the system clock into a game tick (enable), turns raw key presses into one flap request per tick (up), and runs the IDLE/PLAY/DEAD game state machine. Drives gameOver and a one-cycle clear pulse to the light cells, and keeps the score.

---
 rtl/bird_game_if.sv | 24 ++
 rtl/bird_game_ctrl.sv | 121 ++++++++++++
 2 files changed

// File: rtl/bird_game_if.sv
// rtl/bird_game_if.sv - key/collision inputs and game status outputs of the bird game sequencer
interface bird_game_if #(
  parameter int SCORE_W = 7
);
  logic               key;
  logic               collide;
  logic               pipe_pass;
  logic               enable;
  logic               up;
  logic               gameOver;
  logic               clear;
  logic [SCORE_W-1:0] score;
  logic [1:0]         state;

  modport master (
    output key, collide, pipe_pass,
    input  enable, up, gameOver, clear, score, state
  );

  modport slave (
    input  key, collide, pipe_pass,
    output enable, up, gameOver, clear, score, state
  );
endinterface

// File: rtl/bird_game_ctrl.sv
// rtl/bird_game_ctrl.sv - game tick divider, flap request latch and IDLE/PLAY/DEAD sequencer
module bird_game_ctrl #(
  parameter int TICK_DIV  = 8,
  parameter int DEAD_HOLD = 4,
  parameter int SCORE_W   = 7
) (
  input logic       clk,
  input logic       reset,
  bird_game_if.slave bus
);
  localparam int CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam int DW = $clog2(DEAD_HOLD + 2);

  localparam logic [CW-1:0]      TICK_LAST = CW'(TICK_DIV - 1);
  localparam logic [CW-1:0]      CNT_ONE   = 1;
  localparam logic [DW-1:0]      DEAD_MAX  = DW'(DEAD_HOLD);
  localparam logic [DW-1:0]      DEAD_ONE  = 1;
  localparam logic [SCORE_W-1:0] SCORE_MAX = '1;
  localparam logic [SCORE_W-1:0] SCORE_ONE = 1;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    PLAY = 2'b01,
    DEAD = 2'b10
  } state_t;

  state_t             state;
  state_t             nextState;
  logic [CW-1:0]      tickCount;
  logic [DW-1:0]      deadTicks;
  logic               keyQ;
  logic               flapPending;
  logic               clearReg;
  logic [SCORE_W-1:0] scoreReg;

  logic kedge;
  logic tickWrap;
  logic restart;
  logic start;

  assign kedge    = bus.key & ~keyQ;
  assign tickWrap = (tickCount == TICK_LAST);
  assign start    = (state == IDLE) && kedge;
  assign restart  = (state == DEAD) && kedge && (deadTicks == DEAD_MAX);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  always_comb begin
    nextState = IDLE;
    case (state)
      IDLE:    nextState = kedge ? PLAY : IDLE;
      PLAY:    nextState = bus.collide ? DEAD : PLAY;
      DEAD:    nextState = restart ? IDLE : DEAD;
      default: nextState = IDLE;
    endcase
  end

  always_comb begin
    bus.enable   = 1'b0;
    bus.up       = 1'b0;
    bus.gameOver = 1'b0;
    case (state)
      PLAY: begin
        bus.enable = tickWrap;
        bus.up     = flapPending;
      end
      DEAD:    bus.gameOver = 1'b1;
      default: ;
    endcase
  end

  assign bus.clear = clearReg;
  assign bus.score = scoreReg;
  assign bus.state = state;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tickCount   <= '0;
      deadTicks   <= '0;
      keyQ        <= 1'b0;
      flapPending <= 1'b0;
      clearReg    <= 1'b0;
      scoreReg    <= '0;
    end else begin
      keyQ     <= bus.key;
      clearReg <= start || restart;

      // The divider free-runs through DEAD so the hold-off is measured in real ticks.
      if (state == IDLE || state == DEAD && restart || state != PLAY && state != DEAD) begin
        tickCount <= '0;
      end else begin
        tickCount <= tickWrap ? '0 : tickCount + CNT_ONE;
      end

      if (state != DEAD || restart) begin
        deadTicks <= '0;
      end else if (tickWrap && deadTicks != DEAD_MAX) begin
        deadTicks <= deadTicks + DEAD_ONE;
      end

      // A fresh press wins over the tick consuming the request, so it carries to the next tick.
      if (state == PLAY && !bus.collide) begin
        flapPending <= kedge | (flapPending & ~tickWrap);
      end else begin
        flapPending <= 1'b0;
      end

      if (start) begin
        scoreReg <= '0;
      end else if (state == PLAY && bus.pipe_pass && scoreReg != SCORE_MAX) begin
        scoreReg <= scoreReg + SCORE_ONE;
      end
    end
  end
endmodule
